// File: rtl/n64_line_phy.sv
// N64 controller line PHY: serialises an 8-bit command onto the open-drain
// data line and deserialises the controller's 32-bit reply.
module n64_line_phy #(
  parameter int CLKS_PER_US = 100,
  parameter int TIMEOUT_US  = 100
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        pin_in,
  output logic        pin_oe,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [31:0] buttons
);

  localparam int TW = $clog2(4*CLKS_PER_US*TIMEOUT_US + 1);
  localparam logic [TW-1:0] T_1  = TW'(CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_2  = TW'(2*CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_3  = TW'(3*CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_TO = TW'(TIMEOUT_US*CLKS_PER_US - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] TX_LOW    = 4'd1;
  localparam logic [3:0] TX_HIGH   = 4'd2;
  localparam logic [3:0] TX_STOP   = 4'd3;
  localparam logic [3:0] RX_EDGE   = 4'd4;
  localparam logic [3:0] RX_SAMPLE = 4'd5;
  localparam logic [3:0] RX_HIGH   = 4'd6;
  localparam logic [3:0] RX_STOP   = 4'd7;
  localparam logic [3:0] FIN       = 4'd8;

  logic [3:0]    state;
  logic [TW-1:0] tcnt;
  logic [5:0]    bcnt;
  logic [31:0]   sh;
  logic [2:0]    sync;
  logic          pin_s, fall, tmo;

  // sync[1] is the synchronised level; sync[2] is its previous value for edge detection
  assign pin_s = sync[1];
  assign fall  = sync[2] & ~sync[1];
  assign tmo   = (tcnt == '0);

  // Combinational from state so an async reset releases the line immediately
  assign pin_oe = (state == TX_LOW) || (state == TX_STOP);
  assign busy   = (state != IDLE) && (state != FIN);
  assign done   = (state == FIN);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) sync <= 3'b111;
    else          sync <= {sync[1:0], pin_in};
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      sh          <= '0;
      timeout_err <= 1'b0;
      buttons     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh    <= {cmd, 24'h0};
          bcnt  <= 6'd7;
          tcnt  <= cmd[7] ? T_1 : T_3;
          state <= TX_LOW;
        end
        TX_LOW: if (tmo) begin
          tcnt  <= sh[31] ? T_3 : T_1;
          state <= TX_HIGH;
        end else tcnt <= tcnt - TW'(1);
        // command bits leave MSB first from sh[31]
        TX_HIGH: if (tmo) begin
          if (bcnt == 6'd0) begin
            tcnt  <= T_1;
            state <= TX_STOP;
          end else begin
            bcnt  <= bcnt - 6'd1;
            sh    <= {sh[30:0], 1'b0};
            tcnt  <= sh[30] ? T_1 : T_3;
            state <= TX_LOW;
          end
        end else tcnt <= tcnt - TW'(1);
        TX_STOP: if (tmo) begin
          tcnt  <= T_TO;
          bcnt  <= 6'd31;
          state <= RX_EDGE;
        end else tcnt <= tcnt - TW'(1);
        RX_EDGE: if (fall) begin
          tcnt  <= T_2;
          state <= RX_SAMPLE;
        end else if (tmo) begin
          timeout_err <= 1'b1;
          state       <= FIN;
        end else tcnt <= tcnt - TW'(1);
        RX_SAMPLE: if (tmo) begin
          sh   <= {sh[30:0], pin_s};
          tcnt <= T_TO;
          if (bcnt == 6'd0) state <= RX_STOP;
          else begin
            bcnt  <= bcnt - 6'd1;
            state <= RX_HIGH;
          end
        end else tcnt <= tcnt - TW'(1);
        RX_HIGH: if (pin_s) begin
          state <= RX_EDGE;
          if (!tmo) tcnt <= tcnt - TW'(1);
        end else if (tmo) begin
          timeout_err <= 1'b1;
          state       <= FIN;
        end else tcnt <= tcnt - TW'(1);
        // all data is in hand; stop edge or quiet line both count as success
        RX_STOP: if (fall || tmo) begin
          timeout_err <= 1'b0;
          buttons     <= sh;
          state       <= FIN;
        end else tcnt <= tcnt - TW'(1);
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_line_phy.sv
// Scoreboard bench for n64_line_phy: open-drain line model with a scripted
// controller; expected done results are queued and checked by a monitor.
module tb_n64_line_phy;
  localparam int N = 4;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        pin_in;
  logic        pin_oe, busy, done, timeout_err;
  logic [31:0] buttons;

  logic ctrl_low = 1'b0, force_en = 1'b0, force_val = 1'b1;
  assign pin_in = force_en ? force_val : ~(pin_oe | ctrl_low);

  n64_line_phy #(.CLKS_PER_US(N), .TIMEOUT_US(8)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .start(start), .cmd(cmd), .pin_in(pin_in),
    .pin_oe(pin_oe), .busy(busy), .done(done), .timeout_err(timeout_err),
    .buttons(buttons)
  );

  always #5 PCLK = ~PCLK;

  longint cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { logic [31:0] b; logic e; longint dcyc; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge PCLK) begin
    if (PRESERN && done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("buttons", 64'(buttons), 64'(e.b));
        chk("timeout_err", 64'(timeout_err), 64'(e.e));
        chk("busy_at_done", 64'(busy), 64'(0));
        if (e.dcyc >= 0) chk("done_cycle", 64'(cyc), 64'(e.dcyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  // Accepting posedge is c1; afterwards we sit 1 ns into cycle 1
  task automatic start_cmd(input logic [7:0] c, output longint c1);
    cmd = c; start = 1'b1; c1 = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ctrl_low = 1'b1; tick(b ? N : 3*N);
    ctrl_low = 1'b0; tick(b ? 3*N : N);
  endtask

  task automatic reply(input logic [31:0] w, input int nbits, input bit stop);
    for (int i = 0; i < nbits; i++) send_bit(w[31-i]);
    if (stop) begin ctrl_low = 1'b1; tick(2*N); ctrl_low = 1'b0; end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin @(negedge PCLK); n++; end
    chk(nm, 64'(sb.size()), 64'(0));
    tick(2);
  endtask

  function automatic logic exp_oe(input int k);
    if (k < 1)    return 1'b0;
    if (k <= 112) return ((k-1) % 16) < 12;
    if (k <= 128) return (k-113) < 4;
    if (k <= 132) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    longint c1;
    exp_t e;

    // Reset with a toggling line
    force_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      force_val = i[0];
      @(negedge PCLK);
      chk("reset_outputs", 64'({pin_oe, busy, done, timeout_err, buttons}), 64'(0));
    end
    force_en = 1'b0;
    @(posedge PCLK); #1 PRESERN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      chk("idle_outputs", 64'({pin_oe, busy, done, timeout_err, buttons}), 64'(0));
    end
    tick(1);

    // TX waveform for 8'h01 with an ignored start mid TX_HIGH; no reply follows
    start_cmd(8'h01, c1);
    e.b = 32'h0; e.e = 1'b1; e.dcyc = c1 + 164; sb.push_back(e);
    for (int k = 1; k <= 133; k++) begin
      @(negedge PCLK);
      chk($sformatf("tx_oe_k%0d", k), 64'(pin_oe), 64'(exp_oe(k)));
      if (k == 1)  chk("busy_after_start", 64'(busy), 64'(1));
      if (k == 14) begin start = 1'b1; cmd = 8'hFF; end
      if (k == 15) start = 1'b0;
    end
    drain("drain_tx_noreply");

    // Good reply
    start_cmd(8'h01, c1);
    e.b = 32'h800000FF; e.e = 1'b0; e.dcyc = -1; sb.push_back(e);
    tick(131 + 8);
    reply(32'h800000FF, 32, 1'b1);
    drain("drain_rx_good");

    // No reply: previous buttons held
    start_cmd(8'h01, c1);
    e.b = 32'h800000FF; e.e = 1'b1; e.dcyc = c1 + 164; sb.push_back(e);
    drain("drain_noreply");

    // Truncated reply
    start_cmd(8'h01, c1);
    e.b = 32'h800000FF; e.e = 1'b1; e.dcyc = -1; sb.push_back(e);
    tick(131 + 8);
    reply(32'hA5A5_0000, 16, 1'b0);
    drain("drain_truncated");

    // Good reply after the error
    start_cmd(8'h01, c1);
    e.b = 32'h00000001; e.e = 1'b0; e.dcyc = -1; sb.push_back(e);
    tick(131 + 8);
    reply(32'h00000001, 32, 1'b1);
    drain("drain_rx_good2");

    // Reset during bit 3 low phase: line released at once, no done
    start_cmd(8'h00, c1);
    tick(51);
    chk("bit3_oe_before_reset", 64'(pin_oe), 64'(1));
    PRESERN = 1'b0;
    #1;
    chk("reset_oe_release", 64'(pin_oe), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    tick(5);
    PRESERN = 1'b1;
    tick(300);
    chk("post_reset_idle", 64'({pin_oe, busy, timeout_err, buttons}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
